// File: rtl/aiv_pkg.sv
// Shared definitions for the AIV-compatible PAL video generator.
// Contents:
//   pulse_t      - sync pulse type for one half-line (NONE, HSYNC, EQ, BROAD)
//   PAT_*        - pattern_sel codes
//   RGB_*        - RGB111 colour constants, {R,G,B}
//   line numbers - 625-line frame, active ranges, field-2 boundary
//   bar_colour() - colour of each of the eight colour bars
package aiv_pkg;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        HSYNC = 2'd1,
        EQ    = 2'd2,
        BROAD = 2'd3
    } pulse_t;

    localparam logic [1:0] PAT_BARS   = 2'd0;
    localparam logic [1:0] PAT_WHITE  = 2'd1;
    localparam logic [1:0] PAT_BLACK  = 2'd2;
    localparam logic [1:0] PAT_GRILLE = 2'd3;

    localparam logic [2:0] RGB_WHITE   = 3'b111;
    localparam logic [2:0] RGB_YELLOW  = 3'b110;
    localparam logic [2:0] RGB_CYAN    = 3'b011;
    localparam logic [2:0] RGB_GREEN   = 3'b010;
    localparam logic [2:0] RGB_MAGENTA = 3'b101;
    localparam logic [2:0] RGB_RED     = 3'b100;
    localparam logic [2:0] RGB_BLUE    = 3'b001;
    localparam logic [2:0] RGB_BLACK   = 3'b000;

    localparam int LINE_W = 10;
    localparam logic [LINE_W-1:0] LINE_FIRST   = 10'd1;
    localparam logic [LINE_W-1:0] LINE_LAST    = 10'd625;
    localparam logic [LINE_W-1:0] ACT1_FIRST   = 10'd23;
    localparam logic [LINE_W-1:0] ACT1_LAST    = 10'd310;
    localparam logic [LINE_W-1:0] ACT2_FIRST   = 10'd336;
    localparam logic [LINE_W-1:0] ACT2_LAST    = 10'd622;
    localparam logic [LINE_W-1:0] FIELD2_FIRST = 10'd313;

    function automatic logic [2:0] bar_colour(input logic [2:0] bar);
        logic [2:0] c;
        case (bar)
            3'd0:    c = RGB_WHITE;
            3'd1:    c = RGB_YELLOW;
            3'd2:    c = RGB_CYAN;
            3'd3:    c = RGB_GREEN;
            3'd4:    c = RGB_MAGENTA;
            3'd5:    c = RGB_RED;
            3'd6:    c = RGB_BLUE;
            default: c = RGB_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/aiv_sync_table.sv
// Vertical-interval sync table: maps a line number (1..625) and the
// half-line being generated to the sync pulse type for that half-line.
// Ports:
//   line        in  10  current line, 1..625
//   second_half in  1   0 = first half-line, 1 = second half-line
//   pulse       out 2   pulse type (pulse_t)
module aiv_sync_table
    import aiv_pkg::*;
(
    input  logic [LINE_W-1:0] line,
    input  logic              second_half,
    output pulse_t            pulse
);

    always_comb begin
        pulse = NONE;
        if (line <= 10'd2)
            pulse = BROAD;
        else if (line == 10'd3)
            pulse = second_half ? EQ : BROAD;
        else if (line <= 10'd5)
            pulse = EQ;
        else if (line <= ACT1_LAST)
            pulse = second_half ? NONE : HSYNC;
        else if (line < FIELD2_FIRST)
            pulse = EQ;
        else if (line == FIELD2_FIRST)
            pulse = second_half ? BROAD : EQ;
        else if (line <= 10'd315)
            pulse = BROAD;
        else if (line <= 10'd317)
            pulse = EQ;
        else if (line == 10'd318)
            pulse = second_half ? NONE : EQ;
        else if (line <= ACT2_LAST)
            pulse = second_half ? NONE : HSYNC;
        else if (line == 10'd623)
            pulse = second_half ? EQ : HSYNC;
        else
            pulse = EQ;
    end

endmodule

// File: rtl/aiv_video_gen.sv
// AIV-compatible PAL test-pattern generator: 625-line interlaced composite
// sync plus an RGB111 pattern, all registered one cycle after the counters.
// Ports:
//   clk          in  1  system clock
//   reset_n      in  1  synchronous active-low reset
//   run          in  1  1 = generate, 0 = hold at line 1 / h 0 with idle outputs
//   pattern_sel  in  2  bars / white / black / 1-pixel grille, taken at frame top
//   rgb_111      out 3  {R,G,B} pixel
//   csync        out 1  composite sync, active low
//   field        out 1  0 = lines 1-312, 1 = lines 313-625
//   line_start   out 1  strobe for h = 0 of every line
//   frame_start  out 1  strobe for line 1, h = 0
module aiv_video_gen
    import aiv_pkg::*;
#(
    parameter int H_TOTAL   = 1024,
    parameter int HSYNC_W   = 75,
    parameter int EQ_W      = 37,
    parameter int BROAD_W   = 437,
    parameter int ACT_START = 168,
    parameter int ACT_W     = 832
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       run,
    input  logic [1:0] pattern_sel,
    output logic [2:0] rgb_111,
    output logic       csync,
    output logic       field,
    output logic       line_start,
    output logic       frame_start
);

    localparam int H_W = $clog2(H_TOTAL);
    localparam logic [H_W-1:0] H_LAST      = H_W'(H_TOTAL - 1);
    localparam logic [H_W-1:0] HALF_H      = H_W'(H_TOTAL / 2);
    localparam logic [H_W-1:0] HSYNC_H     = H_W'(HSYNC_W);
    localparam logic [H_W-1:0] EQ_H        = H_W'(EQ_W);
    localparam logic [H_W-1:0] BROAD_H     = H_W'(BROAD_W);
    localparam logic [H_W-1:0] ACT_START_H = H_W'(ACT_START);
    localparam logic [H_W-1:0] ACT_W_H     = H_W'(ACT_W);
    localparam logic [H_W-1:0] BAR_H       = H_W'(ACT_W / 8);

    logic [H_W-1:0]    h_cnt_p0;
    logic [LINE_W-1:0] line_p0;
    logic [1:0]        pat_p0;
    logic              second_half;
    logic [H_W-1:0]    half_off;
    logic [H_W-1:0]    act_off;
    logic [H_W-1:0]    pulse_w;
    logic              at_frame_top;
    logic              act_line;
    logic              act_win;
    logic              csync_nxt;
    logic [2:0]        pix;
    pulse_t            pulse;

    // ---- stage p0: counter state, decoded combinationally ----
    assign second_half  = h_cnt_p0 >= HALF_H;
    assign half_off     = second_half ? h_cnt_p0 - HALF_H : h_cnt_p0;
    // Wraps to a large value left of the window; the explicit lower bound
    // below keeps that from looking active.
    assign act_off      = h_cnt_p0 - ACT_START_H;
    assign at_frame_top = (line_p0 == LINE_FIRST) && (h_cnt_p0 == '0);
    assign act_line     = ((line_p0 >= ACT1_FIRST) && (line_p0 <= ACT1_LAST)) ||
                          ((line_p0 >= ACT2_FIRST) && (line_p0 <= ACT2_LAST));
    assign act_win      = act_line && (h_cnt_p0 >= ACT_START_H) && (act_off < ACT_W_H);

    aiv_sync_table u_sync_table (
        .line        (line_p0),
        .second_half (second_half),
        .pulse       (pulse)
    );

    always_comb begin
        pulse_w = '0;
        case (pulse)
            HSYNC:   pulse_w = HSYNC_H;
            EQ:      pulse_w = EQ_H;
            BROAD:   pulse_w = BROAD_H;
            default: pulse_w = '0;
        endcase
        csync_nxt = half_off >= pulse_w;
    end

    always_comb begin
        pix = RGB_BLACK;
        if (act_win) begin
            case (pat_p0)
                PAT_BARS:  pix = bar_colour(3'(act_off / BAR_H));
                PAT_WHITE: pix = RGB_WHITE;
                PAT_BLACK: pix = RGB_BLACK;
                default:   pix = act_off[0] ? RGB_BLACK : RGB_WHITE;
            endcase
        end
    end

    // ---- stage p1: registered outputs, counters advance ----
    always_ff @(posedge clk) begin
        if (!reset_n || !run) begin
            h_cnt_p0    <= '0;
            line_p0     <= LINE_FIRST;
            pat_p0      <= PAT_BARS;
            rgb_111     <= RGB_BLACK;
            csync       <= 1'b1;
            field       <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            rgb_111     <= pix;
            csync       <= csync_nxt;
            field       <= line_p0 >= FIELD2_FIRST;
            line_start  <= h_cnt_p0 == '0;
            frame_start <= at_frame_top;
            // Line 1 has no active video, so the pattern can switch here
            // without a visible tear.
            if (at_frame_top)
                pat_p0 <= pattern_sel;
            if (h_cnt_p0 == H_LAST) begin
                h_cnt_p0 <= '0;
                line_p0  <= (line_p0 == LINE_LAST) ? LINE_FIRST : line_p0 + LINE_W'(1);
            end else begin
                h_cnt_p0 <= h_cnt_p0 + H_W'(1);
            end
        end
    end

endmodule
